smps_frame_rx: RTL and testbench
================================

# smps_frame_rx

Serial receive front end for the SMPS Arduino link. Deserialises 8N1 UART bytes from the Arduino, assembles three consecutive bytes into one 24-bit measurement frame, and presents it as the `received0` word consumed by `encode_decode`: V_panel in [23:16], I_panel in [15:8], V_cap in [7:0]. Frame alignment is recovered from inter-byte gaps, and malformed bytes discard the partial frame. The output holds the last good frame so downstream logic always sees a stable word.

## Interface
- `CLKS_PER_BIT`, default 434: clocks per UART bit (50 MHz / 115200). Must be ≥ 4.
- `GAP_BITS`, default 20: idle bit-times after which a partial frame is discarded.
- `clk`  in  1: system clock. The block uses one clock only.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `rx`  in  1: UART line from the SMPS Arduino. Asynchronous input; idles high.
- `frame`  out  24: last complete frame, {byte0, byte1, byte2}. Connects to `received0`.
- `frame_valid`  out  1: one-cycle pulse when `frame` updates.
- `frame_err`  out  1: one-cycle pulse on a stop-bit error.

## Operation
- **Synchroniser:** `rx` passes through a 2-FF synchroniser with reset value 1. All logic below uses the synchronised signal `rxs`.
- **Bit FSM** has four states: IDLE, START, DATA, STOP.
  - IDLE → START when `rxs` = 0. The bit counter clears.
  - START: count to CLKS_PER_BIT/2 − 1 (integer division), then sample.
    - If `rxs` = 1, the start was a glitch: go to IDLE with no other effect.
    - Otherwise go to DATA with the counter cleared.
  - DATA: sample every CLKS_PER_BIT clocks, 8 samples, LSB first, into the shift register. After bit 7, go to STOP.
  - STOP: sample after CLKS_PER_BIT clocks.
    - `rxs` = 1: byte good.
    - `rxs` = 0: framing error. Pulse `frame_err`, clear byte index to 0, discard the partial frame.
    - Either way, return to IDLE on the same edge. A new start is accepted from the next cycle.
- **Frame assembly:**
  - Byte index runs 0..2. A good byte is stored in slot [index] and the index increments.
  - On the good byte at index 2:
    - `frame` ← {slot0, slot1, byte}.
    - `frame_valid` pulses.
    - Index wraps to 0.
- **Gap timer:**
  - Runs only while in IDLE with index ≠ 0. Clears on entry to START.
  - Reaching GAP_BITS × CLKS_PER_BIT clears the index, silently discarding the partial frame. No `frame_err` pulse.
- **Held output:** `frame` is never modified except on frame completion. Partial frames, errors and timeouts leave it unchanged.
- **Reset values:** `frame` = 0, `frame_valid` = 0, `frame_err` = 0. FSM in IDLE, index 0, all counters 0.
- **Reset mid-byte or mid-frame:** all progress is lost and `frame` returns to 0. After release, reception restarts at the next falling edge.

## Timing
- Input latency: `rx` to `rxs` is 2 cycles.
- Sampling from the `rxs` falling edge:
  - start sample at CLKS_PER_BIT/2 cycles;
  - data bit k sample at CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT;
  - stop sample at CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- `frame` and `frame_valid` are registered on the stop-sample edge, so they are visible the cycle after it. `frame_err` behaves the same way.
- `frame_valid` and `frame_err` are mutually exclusive and never high for more than one cycle.
- Back-to-back bytes with zero idle time are received without loss.
- Timeout boundary:
  - A start edge arriving on the same cycle the gap timer expires is treated as the first byte of a new frame. The index is cleared first.
  - Gap counter width must hold GAP_BITS × CLKS_PER_BIT without overflow.

## Structure
- Shared package `beacon_pkg` holds:
  - `CLKS_PER_BIT_DEFAULT`;
  - `SMPS_FRAME_W` = 24;
  - `SMPS_FRAME_BYTES` = 3;
  - the enum `uart_rx_state_t` {IDLE, START, DATA, STOP}.
- Sub-module `uart_rx_byte`: synchroniser plus bit FSM. Outputs `byte_data[7:0]`, `byte_valid` and `byte_err` pulses, and `idle`.
- Top level `smps_frame_rx`: byte index, slots, gap timer and output registers.
- `uart_rx_byte` is reused later for the ESP32 16-bit link.

## Test plan
All scenarios use CLKS_PER_BIT = 8 and GAP_BITS = 4.

- **Basic frame:** reset, then send 0xA5, 0x3C, 0x7F back-to-back.
  - Exactly one `frame_valid` pulse, 1 cycle after the third stop sample. `frame` = 0xA53C7F.
  - `frame` = 0 before that pulse.
- **Framing error:** send 0x11, then 0x22 with stop bit driven 0, then 0x33, 0x44, 0x55.
  - One `frame_err` pulse and no `frame_valid` for the first group.
  - Then `frame` = 0x334455 with one `frame_valid`.
- **Gap resync:** send 0x01, 0x02, idle 40 clocks, then 0xAA, 0xBB, 0xCC.
  - No `frame_err`, no completion from the partial frame. `frame` = 0xAABBCC.
- **Glitch rejection:** drive `rx` low for 3 clocks in idle, then send 0x10, 0x20, 0x30.
  - No byte is produced by the glitch. `frame` = 0x102030.
- **Hold and reset:** after frame 0xDEADBE, idle 200 clocks.
  - `frame` stays 0xDEADBE with no pulses.
  - Assert `rst_n` mid-byte of the next frame: `frame` = 0 immediately. After release, a fresh 3-byte frame is received correctly.

Source files
------------

// File: rtl/beacon_pkg.sv
// beacon_pkg
// Shared definitions for the beacon serial links.
//   CLKS_PER_BIT_DEFAULT : UART bit period in system clocks (50 MHz / 115200)
//   SMPS_FRAME_W         : width of one SMPS measurement frame
//   SMPS_FRAME_BYTES     : number of UART bytes that make up one SMPS frame
//   uart_rx_state_t      : bit-level receive FSM states
package beacon_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 434;
    localparam int SMPS_FRAME_W         = 24;
    localparam int SMPS_FRAME_BYTES     = 3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
// 8N1 UART byte receiver: 2-FF input synchroniser plus bit-timing FSM.
// Reused by the SMPS (24-bit frame) and ESP32 (16-bit) links.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   rx         in   raw UART line, idles high
//   byte_data  out  last shifted-in byte (valid while byte_valid is high)
//   byte_valid out  high on the stop-sample edge of a byte with a good stop bit
//   byte_err   out  high on the stop-sample edge of a byte with a low stop bit
//   idle       out  FSM is in IDLE
module uart_rx_byte
    import beacon_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_err,
    output logic       idle
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       sync_q;
    logic             rxs;
    uart_rx_state_t   state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       bit_idx, bit_idx_d;
    logic [7:0]       shreg, shreg_d;

    // Synchroniser resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rxs = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_idx_d;
            shreg   <= shreg_d;
        end
    end

    // Byte strobes are combinational on the stop-sample cycle so the frame
    // logic can register them on that same edge.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt + 1'b1;
        bit_idx_d  = bit_idx;
        shreg_d    = shreg;
        byte_valid = 1'b0;
        byte_err   = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_d     = '0;
                    shreg_d   = {rxs, shreg[7:1]};
                    bit_idx_d = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_d      = '0;
                    state_d    = IDLE;
                    byte_valid = rxs;
                    byte_err   = !rxs;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign byte_data = shreg;
    assign idle      = (state == IDLE);

endmodule

// File: rtl/smps_frame_rx.sv
// smps_frame_rx
// Receives three UART bytes from the SMPS Arduino and presents them as one
// held 24-bit word {V_panel, I_panel, V_cap}. Frame alignment is recovered
// by discarding a partial frame after GAP_BITS idle bit-times.
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   rx          in   UART line from the Arduino, idles high
//   frame       out  last complete frame {byte0, byte1, byte2}
//   frame_valid out  one-cycle pulse when frame updates
//   frame_err   out  one-cycle pulse on a stop-bit error
module smps_frame_rx
    import beacon_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int GAP_BITS     = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx,
    output logic [SMPS_FRAME_W-1:0] frame,
    output logic                    frame_valid,
    output logic                    frame_err
);

    localparam int GAP_LIMIT = GAP_BITS * CLKS_PER_BIT;
    localparam int GAP_W     = $clog2(GAP_LIMIT + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LIMIT - 1);
    localparam logic [1:0] LAST_IDX = 2'(SMPS_FRAME_BYTES - 1);

    logic [7:0]       byte_data;
    logic             byte_valid;
    logic             byte_err;
    logic             idle;
    logic [1:0]       idx;
    logic [7:0]       slot0, slot1;
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_expire;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_err  (byte_err),
        .idle      (idle)
    );

    // The gap timer still evaluates on the cycle the FSM leaves IDLE, so an
    // expiry coinciding with a start edge clears the index before that byte lands.
    assign gap_expire = idle && (idx != 2'd0) && (gap_cnt == GAP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (!idle || idx == 2'd0 || gap_expire) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // byte_valid/byte_err only occur outside IDLE, so they never collide with a gap expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            slot0       <= '0;
            slot1       <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (byte_err) begin
                idx       <= '0;
                frame_err <= 1'b1;
            end else if (byte_valid) begin
                if (idx == 2'd0) begin
                    slot0 <= byte_data;
                    idx   <= 2'd1;
                end else if (idx == 2'd1) begin
                    slot1 <= byte_data;
                    idx   <= LAST_IDX;
                end else begin
                    frame       <= {slot0, slot1, byte_data};
                    frame_valid <= 1'b1;
                    idx         <= '0;
                end
            end else if (gap_expire) begin
                idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_smps_frame_rx.sv
// tb_smps_frame_rx
// Scenario-driven bench for smps_frame_rx with CLKS_PER_BIT = 8, GAP_BITS = 4.
// A negedge monitor collects frame_valid/frame_err pulses and guards pulse
// shape and frame hold; each scenario task checks its own expectations.
module tb_smps_frame_rx;

    localparam int CPB  = 8;
    localparam int GAPB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic [23:0] frame;
    logic        frame_valid;
    logic        frame_err;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int last_start = 0;
    logic [23:0] expected_frame = 24'h0;

    logic [23:0] fv_frames[$];
    int          fv_cycles[$];
    int          err_pulses = 0;
    logic        prev_fv = 1'b0;
    logic        prev_fe = 1'b0;
    logic [23:0] prev_frame = 24'h0;

    smps_frame_rx #(
        .CLKS_PER_BIT(CPB),
        .GAP_BITS    (GAPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .frame      (frame),
        .frame_valid(frame_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Pulse collector plus continuous pulse-shape and held-output guards.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            prev_fv    = 1'b0;
            prev_fe    = 1'b0;
            prev_frame = 24'h0;
        end else begin
            if (frame_valid === 1'b1) begin
                fv_frames.push_back(frame);
                fv_cycles.push_back(cycle);
            end
            if (frame_err === 1'b1) err_pulses++;
            checks++;
            if ((frame_valid !== 1'b0 && frame_err !== 1'b0) ||
                (frame_valid !== 1'b0 && prev_fv) ||
                (frame_err !== 1'b0 && prev_fe)) begin
                failures++;
                $display("[TB] FAIL pulse_shape valid=%b err=%b prev_valid=%b prev_err=%b, required exclusive one-cycle pulses",
                         frame_valid, frame_err, prev_fv, prev_fe);
            end
            checks++;
            if (frame_valid !== 1'b1 && frame !== prev_frame) begin
                failures++;
                $display("[TB] FAIL frame_hold got=%h required=%h (no valid pulse)", frame, prev_frame);
            end
            prev_fv    = (frame_valid === 1'b1);
            prev_fe    = (frame_err === 1'b1);
            prev_frame = frame;
        end
    end

    task automatic clear_mon();
        fv_frames.delete();
        fv_cycles.delete();
        err_pulses = 0;
    endtask

    task automatic idle_clks(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one 8N1 byte starting at the current negedge; ends on a negedge.
    task automatic send_byte(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        last_start = cycle;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rx    = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (frame !== 24'h0) begin
            failures++;
            $display("[TB] FAIL reset_frame got=%h required=%h", frame, 24'h0);
        end
        checks++;
        if (frame_valid !== 1'b0 || frame_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_pulses got valid=%b err=%b required 0/0", frame_valid, frame_err);
        end
        rst_n = 1'b1;
        idle_clks(5);
        expected_frame = 24'h0;
    endtask

    task automatic test_basic_frame();
        int start3;
        clear_mon();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        checks++;
        if (frame !== 24'h0) begin
            failures++;
            $display("[TB] FAIL basic_before got=%h required=%h", frame, 24'h0);
        end
        send_byte(8'h7F, 1'b1);
        start3 = last_start;
        idle_clks(10);
        checks++;
        if (fv_frames.size() != 1) begin
            failures++;
            $display("[TB] FAIL basic_count got=%0d required=1", fv_frames.size());
        end else begin
            checks++;
            if (fv_cycles[0] != start3 + 79) begin
                failures++;
                $display("[TB] FAIL basic_latency got=%0d required=%0d", fv_cycles[0] - start3, 79);
            end
        end
        checks++;
        if (frame !== 24'hA53C7F) begin
            failures++;
            $display("[TB] FAIL basic_frame got=%h required=%h", frame, 24'hA53C7F);
        end
        checks++;
        if (err_pulses != 0) begin
            failures++;
            $display("[TB] FAIL basic_err got=%0d required=0", err_pulses);
        end
        expected_frame = 24'hA53C7F;
    endtask

    task automatic test_framing_error();
        clear_mon();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        idle_clks(20);
        checks++;
        if (err_pulses != 1 || fv_frames.size() != 0) begin
            failures++;
            $display("[TB] FAIL ferr_first got err=%0d valid=%0d required err=1 valid=0", err_pulses, fv_frames.size());
        end
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        idle_clks(10);
        checks++;
        if (fv_frames.size() != 1 || err_pulses != 1) begin
            failures++;
            $display("[TB] FAIL ferr_count got valid=%0d err=%0d required valid=1 err=1", fv_frames.size(), err_pulses);
        end
        checks++;
        if (frame !== 24'h334455) begin
            failures++;
            $display("[TB] FAIL ferr_frame got=%h required=%h", frame, 24'h334455);
        end
        expected_frame = 24'h334455;
    endtask

    task automatic test_gap_resync();
        clear_mon();
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        idle_clks(40);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        idle_clks(10);
        checks++;
        if (fv_frames.size() != 1 || err_pulses != 0) begin
            failures++;
            $display("[TB] FAIL gap_count got valid=%0d err=%0d required valid=1 err=0", fv_frames.size(), err_pulses);
        end
        checks++;
        if (frame !== 24'hAABBCC) begin
            failures++;
            $display("[TB] FAIL gap_frame got=%h required=%h", frame, 24'hAABBCC);
        end
        expected_frame = 24'hAABBCC;
    endtask

    task automatic test_glitch();
        clear_mon();
        rx = 1'b0;
        repeat (3) @(negedge clk);
        idle_clks(10);
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b1);
        send_byte(8'h30, 1'b1);
        idle_clks(10);
        checks++;
        if (fv_frames.size() != 1 || err_pulses != 0) begin
            failures++;
            $display("[TB] FAIL glitch_count got valid=%0d err=%0d required valid=1 err=0", fv_frames.size(), err_pulses);
        end
        checks++;
        if (frame !== 24'h102030) begin
            failures++;
            $display("[TB] FAIL glitch_frame got=%h required=%h", frame, 24'h102030);
        end
        expected_frame = 24'h102030;
    endtask

    task automatic test_hold_and_reset();
        logic [7:0] b0, b1, b2;
        clear_mon();
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        idle_clks(200);
        checks++;
        if (frame !== 24'hDEADBE || fv_frames.size() != 1 || err_pulses != 0) begin
            failures++;
            $display("[TB] FAIL hold_frame got=%h valid=%0d err=%0d required=%h valid=1 err=0",
                     frame, fv_frames.size(), err_pulses, 24'hDEADBE);
        end
        rx = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (frame !== 24'h0 || frame_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid got=%h valid=%b required=%h valid=0", frame, frame_valid, 24'h0);
        end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_clks(10);
        clear_mon();
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
        idle_clks(10);
        checks++;
        if (frame !== {b0, b1, b2} || fv_frames.size() != 1) begin
            failures++;
            $display("[TB] FAIL post_reset got=%h valid=%0d required=%h valid=1", frame, fv_frames.size(), {b0, b1, b2});
        end
        expected_frame = {b0, b1, b2};
    endtask

    // Byte-level reference: good bytes fill slots in order, a bad stop or a
    // long idle gap drops the partial frame, the third good byte completes it.
    task automatic test_random();
        logic [23:0] exp_q[$];
        logic [7:0]  ms0, ms1, d;
        logic [23:0] model_frame;
        int          midx, exp_err, gap;
        bit          bad, prev_bad;
        clear_mon();
        idle_clks(60);
        midx        = 0;
        exp_err     = 0;
        prev_bad    = 1'b0;
        ms0         = 8'h0;
        ms1         = 8'h0;
        model_frame = expected_frame;
        for (int n = 0; n < 30; n++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 4) == 0) begin
                gap  = int'($urandom_range(40, 60));
                midx = 0;
            end else begin
                gap = int'($urandom_range(0, 8));
            end
            if (prev_bad && gap < 16) gap = 16;
            idle_clks(gap);
            send_byte(d, !bad);
            prev_bad = bad;
            if (bad) begin
                midx = 0;
                exp_err++;
            end else if (midx == 0) begin
                ms0  = d;
                midx = 1;
            end else if (midx == 1) begin
                ms1  = d;
                midx = 2;
            end else begin
                exp_q.push_back({ms0, ms1, d});
                model_frame = {ms0, ms1, d};
                midx = 0;
            end
        end
        idle_clks(60);
        checks++;
        if (fv_frames.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL rand_count got=%0d required=%0d", fv_frames.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (fv_frames[i] !== exp_q[i]) begin
                    failures++;
                    $display("[TB] FAIL rand_frame[%0d] got=%h required=%h", i, fv_frames[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (err_pulses != exp_err) begin
            failures++;
            $display("[TB] FAIL rand_err got=%0d required=%0d", err_pulses, exp_err);
        end
        checks++;
        if (frame !== model_frame) begin
            failures++;
            $display("[TB] FAIL rand_held got=%h required=%h", frame, model_frame);
        end
        expected_frame = model_frame;
    endtask

    initial begin
        rx    = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        $display("[TB] starting smps_frame_rx scenarios");
        test_reset();
        test_basic_frame();
        test_framing_error();
        test_gap_resync();
        test_glitch();
        test_hold_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
